main_mem_arbiter: RTL and testbench

- Sits directly downstream of each core's memory stage; consumes its main_mem_* request/handshake and lock_* signals.
- Arbitrates NCORE cores onto one single-port synchronous main memory (1-cycle read latency).
- Maintains a 16-entry lock table used by the cores for mutual exclusion.

---
 rtl/main_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_main_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter of NCORE cores onto one single-port synchronous memory,
// plus an independent 16-entry lock table for inter-core mutual exclusion.
module main_mem_arbiter #(
  parameter int NCORE = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCORE-1:0]    core_rd_req,
  input  logic [NCORE-1:0]    core_wr_req,
  input  logic [NCORE*AW-1:0] core_rd_adr,
  input  logic [NCORE*AW-1:0] core_wr_adr,
  input  logic [NCORE*DW-1:0] core_wr_dat,
  output logic [NCORE-1:0]    core_ac,
  output logic [DW-1:0]       core_rdat,
  input  logic [NCORE*4-1:0]  core_lock_adr,
  input  logic [NCORE-1:0]    core_lock_en,
  input  logic [NCORE-1:0]    core_unlock_en,
  output logic [NCORE-1:0]    core_lock_ac,
  output logic [AW-1:0]       mem_adr,
  output logic [DW-1:0]       mem_wdat,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DW-1:0]       mem_rdat
);

  localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  // Returns {found, index}: first requester strictly after ptr, wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NCORE-1:0] req,
                                          input logic [IW-1:0]    ptr);
    logic [IW:0] r;
    int          idx;
    r   = '0;
    idx = 0;
    for (int k = NCORE; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NCORE;
      if (req[idx]) r = {1'b1, idx[IW-1:0]};
    end
    return r;
  endfunction

  logic [NCORE-1:0][AW-1:0] w_rd_adr, w_wr_adr;
  logic [NCORE-1:0][DW-1:0] w_wr_dat;
  logic [NCORE-1:0][3:0]    w_lk_idx;

  assign w_rd_adr = core_rd_adr;
  assign w_wr_adr = core_wr_adr;
  assign w_wr_dat = core_wr_dat;
  assign w_lk_idx = core_lock_adr;

  // ---------------- memory FSM ----------------
  state_t        r_state, w_state_n;
  logic [IW-1:0] r_rr, r_win, w_win;
  logic          r_rd, w_found, w_is_wr;
  logic [DW-1:0] r_rdat;
  logic [IW:0]   w_mpick;

  assign w_mpick = rr_pick(core_rd_req | core_wr_req, r_rr);
  assign w_found = w_mpick[IW];
  assign w_win   = w_mpick[IW-1:0];
  // A core holding both requests gets its write first; the read re-competes.
  assign w_is_wr = core_wr_req[w_win];

  always_comb begin
    w_state_n = r_state;
    mem_adr   = '0;
    mem_wdat  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    core_ac   = '0;
    if (reset) begin
      case (r_state)
        IDLE: if (w_found) begin
          w_state_n = ACCESS;
          mem_we    = w_is_wr;
          mem_re    = !w_is_wr;
          mem_adr   = w_is_wr ? w_wr_adr[w_win] : w_rd_adr[w_win];
          mem_wdat  = w_is_wr ? w_wr_dat[w_win] : '0;
        end
        ACCESS: begin
          w_state_n      = IDLE;
          core_ac[r_win] = 1'b1;
        end
      endcase
    end
  end

  assign core_rdat = (r_state == ACCESS && r_rd) ? mem_rdat : r_rdat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_rr    <= IW'(NCORE - 1);
      r_win   <= '0;
      r_rd    <= 1'b0;
      r_rdat  <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE && w_found) begin
        r_win <= w_win;
        r_rd  <= !w_is_wr;
        r_rr  <= w_win;
      end
      if (r_state == ACCESS && r_rd) r_rdat <= mem_rdat;
    end
  end

  // ---------------- lock unit ----------------
  logic [15:0]           r_lk_vld;
  logic [15:0][IW-1:0]   r_lk_own;
  logic [IW-1:0]         r_lrr, w_lwin;
  logic [NCORE-1:0]      r_lk_ac, w_lk_cand;
  logic [IW:0]           w_lpick;
  logic [3:0]            w_lidx;
  logic                  w_lfound, w_mine;

  // A core being acked this cycle still shows its request; skip it.
  assign w_lk_cand = (core_lock_en | core_unlock_en) & ~r_lk_ac;
  assign w_lpick   = rr_pick(w_lk_cand, r_lrr);
  assign w_lfound  = w_lpick[IW];
  assign w_lwin    = w_lpick[IW-1:0];
  assign w_lidx    = w_lk_idx[w_lwin];
  assign w_mine    = r_lk_vld[w_lidx] && (r_lk_own[w_lidx] == w_lwin);

  assign core_lock_ac = r_lk_ac;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lk_vld <= '0;
      r_lk_own <= '0;
      r_lrr    <= IW'(NCORE - 1);
      r_lk_ac  <= '0;
    end else begin
      r_lk_ac <= '0;
      if (w_lfound) begin
        r_lrr <= w_lwin;
        if (core_unlock_en[w_lwin]) begin
          r_lk_ac[w_lwin] <= 1'b1;
          if (w_mine) r_lk_vld[w_lidx] <= 1'b0;
        end else if (!r_lk_vld[w_lidx] || w_mine) begin
          r_lk_vld[w_lidx] <= 1'b1;
          r_lk_own[w_lidx] <= w_lwin;
          r_lk_ac[w_lwin]  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: scoreboard of expected acks/read data,
// a behavioural synchronous memory, and lock-table handshake scenarios.
module tb_main_mem_arbiter;
  localparam int NCORE = 2;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCORE-1:0]    rd_req, wr_req, lock_en, unlock_en;
  logic [NCORE*AW-1:0] rd_adr, wr_adr;
  logic [NCORE*DW-1:0] wr_dat;
  logic [NCORE*4-1:0]  lock_adr;
  logic [NCORE-1:0]    core_ac, core_lock_ac;
  logic [DW-1:0]       core_rdat, mem_wdat, mem_rdat;
  logic [AW-1:0]       mem_adr;
  logic                mem_we, mem_re;

  main_mem_arbiter #(.NCORE(NCORE), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .core_rd_req(rd_req), .core_wr_req(wr_req),
    .core_rd_adr(rd_adr), .core_wr_adr(wr_adr), .core_wr_dat(wr_dat),
    .core_ac(core_ac), .core_rdat(core_rdat),
    .core_lock_adr(lock_adr), .core_lock_en(lock_en), .core_unlock_en(unlock_en),
    .core_lock_ac(core_lock_ac),
    .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdat(mem_rdat)
  );

  always #5 clk = ~clk;

  // Memory contents are (re)loaded while reset is held.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h20] <= 16'hCAFE;
    end else if (mem_we) mem[mem_adr[7:0]] <= mem_wdat;
    if (mem_re) mem_rdat <= mem[mem_adr[7:0]];
  end

  typedef struct { int core; bit rd; logic [DW-1:0] dat; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0, ncyc = 0;
  bit sticky = 1'b0;
  logic [NCORE-1:0] ac_now, lac_now;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input bit rd, input logic [DW-1:0] d);
    exp_t e;
    e.core = c; e.rd = rd; e.dat = d;
    sb.push_back(e);
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    rd_adr[c*AW +: AW] = a;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_adr[c*AW +: AW] = a;
    wr_dat[c*DW +: DW] = d;
  endtask

  task automatic set_lk(input int c, input logic [3:0] idx);
    lock_adr[c*4 +: 4] = idx;
  endtask

  // One cycle: sample at the falling edge, score acks, and let the cores drop
  // whatever request was just acknowledged.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    ncyc++;
    ac_now  = core_ac;
    lac_now = core_lock_ac;
    chk("ac_onehot0", 32'($onehot0(core_ac)), 1);
    chk("lock_ac_onehot0", 32'($onehot0(core_lock_ac)), 1);
    if (core_ac != '0) begin
      if (sb.size() == 0) chk("ac_unexpected", 32'(core_ac), 0);
      else begin
        e = sb.pop_front();
        chk("ac_core", 32'(core_ac), 32'(1) << e.core);
        if (e.rd) begin
          chk("rdat", 32'(core_rdat), 32'(e.dat));
          if (!sticky) rd_req[e.core] = 1'b0;
        end else wr_req[e.core] = 1'b0;
      end
    end
    for (int i = 0; i < NCORE; i++)
      if (core_lock_ac[i]) begin lock_en[i] = 1'b0; unlock_en[i] = 1'b0; end
  endtask

  task automatic run_gap(input int n);
    int prev;
    prev = -1;
    for (int k = 0; k < n; k++) begin
      cyc();
      if (ac_now != '0) begin
        if (prev >= 0) chk("ac_gap", 32'(ncyc - prev), 2);
        prev = ncyc;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    reset = 1'b0;
    rd_req = '0; wr_req = '0; lock_en = '0; unlock_en = '0;
    rd_adr = '0; wr_adr = '0; wr_dat = '0; lock_adr = '0;
    repeat (2) cyc();
    chk("rst_ac", 32'(core_ac), 0);
    chk("rst_lock_ac", 32'(core_lock_ac), 0);
    chk("rst_mem_re", 32'(mem_re), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_adr", 32'(mem_adr), 0);
    chk("rst_rdat", 32'(core_rdat), 0);
    reset = 1'b1;
    cyc();

    // Single read
    set_rd(0, 16'h0010); rd_req[0] = 1'b1; push(0, 1'b1, 16'hBEEF);
    #1;
    chk("t1_mem_re", 32'(mem_re), 1);
    chk("t1_mem_we", 32'(mem_we), 0);
    chk("t1_mem_adr", 32'(mem_adr), 32'h0010);
    cyc();
    chk("t1_ac", 32'(ac_now), 1);
    cyc();
    chk("t1_idle_re", 32'(mem_re), 0);
    chk("t1_idle_ac", 32'(core_ac), 0);
    chk("t1_rdat_hold", 32'(core_rdat), 32'hBEEF);

    // Contention from reset: core0 first, strict alternation
    reset = 1'b0; cyc(); reset = 1'b1;
    set_rd(0, 16'h0010); set_rd(1, 16'h0020);
    rd_req = 2'b11; sticky = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b1, 16'hBEEF);
      push(1, 1'b1, 16'hCAFE);
    end
    run_gap(11);
    rd_req = '0; sticky = 1'b0;
    cyc();
    chk("t2_sb_empty", 32'(sb.size()), 0);
    chk("t2_idle_re", 32'(mem_re), 0);

    // Write then readback by core1
    set_wr(1, 16'h00FF, 16'h1234); wr_req[1] = 1'b1; push(1, 1'b0, '0);
    #1;
    chk("t3_mem_we", 32'(mem_we), 1);
    chk("t3_mem_re", 32'(mem_re), 0);
    chk("t3_mem_adr", 32'(mem_adr), 32'h00FF);
    chk("t3_mem_wdat", 32'(mem_wdat), 32'h1234);
    cyc(); cyc();
    set_rd(1, 16'h00FF); rd_req[1] = 1'b1; push(1, 1'b1, 16'h1234);
    #1;
    chk("t3_rd_adr", 32'(mem_adr), 32'h00FF);
    cyc(); cyc();
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Simultaneous read+write from core0: write first, read two cycles later
    set_wr(0, 16'h0030, 16'h5A5A); set_rd(0, 16'h0030);
    rd_req[0] = 1'b1; wr_req[0] = 1'b1;
    push(0, 1'b0, '0); push(0, 1'b1, 16'h5A5A);
    #1;
    chk("t6_we_first", 32'(mem_we), 1);
    chk("t6_re_first", 32'(mem_re), 0);
    run_gap(4);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    // Lock conflict on entry 3
    set_lk(0, 4'd3); lock_en[0] = 1'b1;
    cyc();
    chk("t4_acq0", 32'(lac_now), 1);
    set_lk(1, 4'd3); lock_en[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t4_blocked", 32'(lac_now), 0);
    end
    unlock_en[0] = 1'b1;
    cyc();
    chk("t4_rel0", 32'(lac_now), 1);
    got = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      if (lac_now == 2'b10) got = 1'b1;
    end
    chk("t4_acq1_after_rel", 32'(got), 1);
    // Release by a non-owner is acked but leaves core1 holding the lock
    unlock_en[0] = 1'b1;
    cyc();
    chk("t4_rel_not_owner", 32'(lac_now), 1);
    lock_en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t4_still_owned", 32'(lac_now), 0);
    end
    unlock_en[1] = 1'b1;
    cyc();
    chk("t4_rel1", 32'(lac_now), 2);
    cyc();
    chk("t4_acq0_again", 32'(lac_now), 1);

    // Reset during ACCESS of a core0 read; core0 still owns lock 3
    set_rd(0, 16'h0010); rd_req[0] = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_ac", 32'(core_ac), 0);
    chk("t5_mem_re", 32'(mem_re), 0);
    chk("t5_mem_we", 32'(mem_we), 0);
    chk("t5_lock_ac", 32'(core_lock_ac), 0);
    cyc();
    chk("t5_held_re", 32'(mem_re), 0);
    reset = 1'b1;
    push(0, 1'b1, 16'hBEEF);
    set_lk(1, 4'd3); lock_en[1] = 1'b1;
    #1;
    chk("t5_fresh_re", 32'(mem_re), 1);
    cyc();
    chk("t5_fresh_ac", 32'(ac_now), 1);
    chk("t5_lock_cleared", 32'(lac_now), 2);
    cyc();
    chk("t5_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
